// File: rtl/vga_pkg.sv
// Shared VGA-path definitions.
//   colour_t       : 12-bit RGB444 pixel
//   TRANSPARENT    : colour value meaning "no pixel from this source"
//   DEF_H_ACTIVE   : default visible pixels per line
//   DEF_V_ACTIVE   : default visible lines per frame
//   CNT_W          : width of the raster counters hcount/vcount
package vga_pkg;

  typedef logic [11:0] colour_t;

  localparam colour_t TRANSPARENT  = 12'h000;
  localparam int      DEF_H_ACTIVE = 640;
  localparam int      DEF_V_ACTIVE = 480;
  localparam int      CNT_W        = 10;

endpackage

// File: rtl/sprite_ram.sv
// Sprite bitmap store: DEPTH x colour_t simple dual-port RAM.
// One write port and one read port on the same clock. The read is registered
// and read-first: a read and a write to the same address in one cycle return
// the old contents. Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write colour
//   raddr  in   read address (sampled every cycle)
//   rdata  out  registered read data, one cycle after raddr
module sprite_ram
  import vga_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  colour_t       wdata,
  input  logic [AW-1:0] raddr,
  output colour_t       rdata
);

  colour_t mem [DEPTH];
  colour_t rdata_reg;

  // Both ports in one process: the read samples mem before the write lands,
  // which gives read-first behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sprite_layer.sv
// Single hardware sprite colour source for the VGA path.
// Emits the sprite texel colour for the current raster position, or
// TRANSPARENT (12'h000) when the sprite does not cover it. Position and
// enable are written by the CPU into shadow registers and copied into the
// active registers at frame_start, so a frame never shows a half-moved sprite.
// Fixed latency of 2 clocks from hcount/vcount/de to pix_out.
// Optional feature: define SPRITE_HFLIP_EN to add the hflip input, a
// horizontal mirror flag buffered the same way as the position.
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   hcount       in   current pixel column
//   vcount       in   current line
//   de           in   display enable (active video)
//   frame_start  in   one-cycle pulse at the start of a frame
//   bm_we        in   bitmap write strobe
//   bm_addr      in   bitmap address, row*SPR_W+col
//   bm_data      in   bitmap colour (12'h000 = transparent texel)
//   pos_we       in   shadow position/enable write strobe
//   pos_x        in   new top-left column
//   pos_y        in   new top-left line
//   spr_en       in   new sprite-visible flag
//   hflip        in   new mirror flag (SPRITE_HFLIP_EN builds only)
//   pix_out      out  sprite colour or 12'h000
module sprite_layer
  import vga_pkg::*;
#(
  parameter  int SPR_W    = 16,
  parameter  int SPR_H    = 16,
  parameter  int H_ACTIVE = DEF_H_ACTIVE,
  parameter  int V_ACTIVE = DEF_V_ACTIVE,
  localparam int AW       = $clog2(SPR_W*SPR_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             de,
  input  logic             frame_start,
  input  logic             bm_we,
  input  logic [AW-1:0]    bm_addr,
  input  logic [11:0]      bm_data,
  input  logic             pos_we,
  input  logic [CNT_W-1:0] pos_x,
  input  logic [CNT_W-1:0] pos_y,
  input  logic             spr_en,
`ifdef SPRITE_HFLIP_EN
  input  logic             hflip,
`endif
  output logic [11:0]      pix_out
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  // ---------------------------------------------------------------------
  // Shadow and active position registers
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] x_shadow_reg, y_shadow_reg;
  logic [CNT_W-1:0] x_act_reg, y_act_reg;
  logic             en_shadow_reg, en_act_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_shadow_reg  <= '0;
      y_shadow_reg  <= '0;
      en_shadow_reg <= 1'b0;
      x_act_reg     <= '0;
      y_act_reg     <= '0;
      en_act_reg    <= 1'b0;
    end else begin
      if (pos_we) begin
        x_shadow_reg  <= pos_x;
        y_shadow_reg  <= pos_y;
        en_shadow_reg <= spr_en;
      end
      // A write coinciding with frame_start bypasses the shadow so the new
      // value is not lost for a whole frame.
      if (frame_start) begin
        x_act_reg  <= pos_we ? pos_x  : x_shadow_reg;
        y_act_reg  <= pos_we ? pos_y  : y_shadow_reg;
        en_act_reg <= pos_we ? spr_en : en_shadow_reg;
      end
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic flip_shadow_reg, flip_act_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_shadow_reg <= 1'b0;
      flip_act_reg    <= 1'b0;
    end else begin
      if (pos_we) begin
        flip_shadow_reg <= hflip;
      end
      if (frame_start) begin
        flip_act_reg <= pos_we ? hflip : flip_shadow_reg;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Stage 1: hit test and bitmap address
  // ---------------------------------------------------------------------
  // One extra bit so that a raster position left of / above the sprite
  // yields a large value (sign bit set) instead of wrapping into range.
  logic [CNT_W:0] dh, dv;
  logic           hit_h, hit_v, in_visible, hit;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [AW-1:0]  rd_addr;

  assign dh = {1'b0, hcount} - {1'b0, x_act_reg};
  assign dv = {1'b0, vcount} - {1'b0, y_act_reg};

  assign hit_h      = !dh[CNT_W] && (dh < (CNT_W+1)'(SPR_W));
  assign hit_v      = !dv[CNT_W] && (dv < (CNT_W+1)'(SPR_H));
  assign in_visible = (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
  assign hit        = en_act_reg && de && in_visible && hit_h && hit_v;

`ifdef SPRITE_HFLIP_EN
  assign col = flip_act_reg ? (CW'(SPR_W-1) - dh[CW-1:0]) : dh[CW-1:0];
`else
  assign col = dh[CW-1:0];
`endif
  assign row = dv[RW-1:0];

  // SPR_W is a power of two, so row*SPR_W+col is a plain concatenation.
  assign rd_addr = {row, col};

  colour_t ram_q;

  sprite_ram #(
    .DEPTH (SPR_W*SPR_H)
  ) u_ram (
    .clk   (clk),
    .we    (bm_we),
    .waddr (bm_addr),
    .wdata (bm_data),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // ---------------------------------------------------------------------
  // Stage 2: select texel or transparent
  // ---------------------------------------------------------------------
  logic    hit_d_reg;
  colour_t pix_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_d_reg <= 1'b0;
      pix_reg   <= TRANSPARENT;
    end else begin
      hit_d_reg <= hit;
      pix_reg   <= hit_d_reg ? ram_q : TRANSPARENT;
    end
  end

  assign pix_out = pix_reg;

endmodule

// File: tb/tb_sprite_layer.sv
// Bench for sprite_layer: a frame-level reference model predicts the pixel
// for every raster position and is compared each cycle; directed probes pin
// hand-computed literal values.
module tb_sprite_layer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        de = 1'b0;
  logic        frame_start = 1'b0;
  logic        bm_we = 1'b0;
  logic [7:0]  bm_addr = '0;
  logic [11:0] bm_data = '0;
  logic        pos_we = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        spr_en = 1'b0;
  logic        hf = 1'b0;
  logic [11:0] pix_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sprite_layer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .frame_start (frame_start),
    .bm_we       (bm_we),
    .bm_addr     (bm_addr),
    .bm_data     (bm_data),
    .pos_we      (pos_we),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .spr_en      (spr_en),
`ifdef SPRITE_HFLIP_EN
    .hflip       (hf),
`endif
    .pix_out     (pix_out)
  );

  // ---------------- reference model ----------------
  logic [11:0] m_bmp [256];
  int          m_sx, m_sy, m_ax, m_ay;
  bit          m_sen, m_aen, m_shf, m_ahf;
  logic [11:0] exp1, exp2;

  // Colour the sprite must show at raster (h,v), from the sprite rules.
  function automatic logic [11:0] model_pix(int h, int v, bit d);
    int dx, dy, c;
    if (!m_aen || !d || h >= 640 || v >= 480) return 12'h000;
    dx = h - m_ax;
    dy = v - m_ay;
    if (dx < 0 || dx >= 16 || dy < 0 || dy >= 16) return 12'h000;
    c = m_ahf ? 15 - dx : dx;
    return m_bmp[dy*16 + c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sx <= 0; m_sy <= 0; m_sen <= 0; m_shf <= 0;
      m_ax <= 0; m_ay <= 0; m_aen <= 0; m_ahf <= 0;
      exp1 <= 12'h000;
      exp2 <= 12'h000;
    end else begin
      exp1 <= model_pix(int'(hcount), int'(vcount), de);
      exp2 <= exp1;
      if (bm_we) m_bmp[bm_addr] <= bm_data;
      if (pos_we) begin
        m_sx <= int'(pos_x); m_sy <= int'(pos_y); m_sen <= spr_en; m_shf <= hf;
      end
      if (frame_start) begin
        if (pos_we) begin
          m_ax <= int'(pos_x); m_ay <= int'(pos_y); m_aen <= spr_en; m_ahf <= hf;
        end else begin
          m_ax <= m_sx; m_ay <= m_sy; m_aen <= m_sen; m_ahf <= m_shf;
        end
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    checks++;
    if (pix_out !== exp2) begin
      errors++;
      $display("FAIL stream t=%0t pix_out=%h expected=%h", $time, pix_out, exp2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raster(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    de     = (h < 640) && (v < 480);
  endtask

  function automatic logic [11:0] bmp_pat(input int mode, input int a);
    case (mode)
      0:       return 12'hF00;
      1:       return 12'h100 | 12'(a);
      2:       return (a == 3) ? 12'h000 : 12'h0F0;
      default: return ((a % 16) == 0) ? 12'h00F : 12'h111;
    endcase
  endfunction

  task automatic load_bmp(input int mode);
    de = 1'b0;
    for (int a = 0; a < 256; a++) begin
      bm_we = 1'b1; bm_addr = 8'(a); bm_data = bmp_pat(mode, a);
      tick();
    end
    bm_we = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y, input bit en, input bit fl, input bit fs);
    de = 1'b0;
    pos_we = 1'b1; pos_x = 10'(x); pos_y = 10'(y); spr_en = en; hf = fl;
    frame_start = fs;
    tick();
    pos_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame();
    de = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) begin
        set_raster(h, v);
        tick();
      end
    de = 1'b0;
    tick();
    tick();
  endtask

  task automatic probe_w(input string name, input int h, input int v,
                         input bit we, input int addr, input logic [11:0] wd,
                         input logic [11:0] expv);
    set_raster(h, v);
    bm_we = we; bm_addr = 8'(addr); bm_data = wd;
    tick();
    bm_we = 1'b0; de = 1'b0;
    tick();
    checks++;
    if (pix_out !== expv) begin
      errors++;
      $display("FAIL probe %s h=%0d v=%0d pix_out=%h expected=%h", name, h, v, pix_out, expv);
    end else begin
      $display("probe %s h=%0d v=%0d pix_out=%h ok", name, h, v, pix_out);
    end
  endtask

  task automatic probe(input string name, input int h, input int v, input logic [11:0] expv);
    probe_w(name, h, v, 1'b0, 0, 12'h000, expv);
  endtask

  task automatic check_now(input string name, input logic [11:0] expv);
    checks++;
    if (pix_out !== expv) begin
      errors++;
      $display("FAIL %s pix_out=%h expected=%h", name, pix_out, expv);
    end else begin
      $display("check %s pix_out=%h ok", name, pix_out);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held with active video running.
    #1;
    for (int h = 0; h < 30; h++) begin
      set_raster(h, 0);
      frame_start = (h == 0);
      tick();
    end
    frame_start = 1'b0;
    check_now("in_reset", 12'h000);
    rst_n = 1'b1;
    frame();
    scan(0, 20, 0, 2);
    probe("reset_hidden", 0, 0, 12'h000);

    // Solid sprite at (100,50).
    load_bmp(0);
    set_pos(100, 50, 1'b1, 1'b0, 1'b0);
    probe("before_frame", 100, 50, 12'h000);
    frame();
    scan(95, 120, 45, 70);
    probe("tl", 100, 50, 12'hF00);
    probe("left_miss", 99, 50, 12'h000);
    probe("br", 115, 65, 12'hF00);
    probe("right_miss", 116, 65, 12'h000);
    probe("below_miss", 115, 66, 12'h000);

    // Mid-frame move is deferred; move with frame_start is immediate.
    set_pos(200, 200, 1'b1, 1'b0, 1'b0);
    scan(95, 120, 45, 70);
    probe("old_kept", 100, 50, 12'hF00);
    probe("new_pending", 200, 200, 12'h000);
    frame();
    scan(195, 220, 195, 220);
    probe("new_live", 200, 200, 12'hF00);
    probe("old_gone", 100, 50, 12'h000);
    set_pos(300, 300, 1'b1, 1'b0, 1'b1);
    probe("same_cycle", 300, 300, 12'hF00);
    probe("same_cycle_old", 200, 200, 12'h000);

    // Right and bottom clipping with distinct texels.
    load_bmp(1);
    set_pos(632, 100, 1'b1, 1'b0, 1'b1);
    scan(620, 660, 99, 101);
    scan(0, 12, 100, 101);
    probe("clip_first", 632, 100, 12'h100);
    probe("clip_last", 639, 100, 12'h107);
    probe("clip_left", 631, 100, 12'h000);
    probe("clip_blank", 640, 100, 12'h000);
    probe("no_wrap", 0, 101, 12'h000);
    probe("clip_row1", 639, 101, 12'h117);
    set_pos(300, 470, 1'b1, 1'b0, 1'b1);
    scan(295, 320, 465, 490);
    probe("bot_row9", 300, 479, 12'h190);
    probe("bot_corner", 315, 479, 12'h19F);
    probe("bot_clip", 300, 480, 12'h000);

    // Transparent texel and read/write collision.
    load_bmp(2);
    set_pos(100, 50, 1'b1, 1'b0, 1'b1);
    scan(98, 118, 49, 52);
    probe("clear_texel", 103, 50, 12'h000);
    probe("texel_c2", 102, 50, 12'h0F0);
    probe("texel_r1c3", 103, 51, 12'h0F0);
    probe_w("collide_old", 105, 50, 1'b1, 5, 12'hABC, 12'h0F0);
    probe("collide_new", 105, 50, 12'hABC);

`ifdef SPRITE_HFLIP_EN
    load_bmp(3);
    set_pos(100, 50, 1'b1, 1'b1, 1'b1);
    scan(98, 118, 49, 52);
    probe("flip_col0", 115, 50, 12'h00F);
    probe("flip_col15", 100, 50, 12'h111);
    probe("flip_col1", 114, 50, 12'h111);
    set_pos(100, 50, 1'b1, 1'b0, 1'b1);
    hf = 1'b0;
`endif

    // Mid-frame reset hides the sprite until re-enabled and a new frame.
    load_bmp(0);
    set_pos(100, 50, 1'b1, 1'b0, 1'b1);
    set_raster(105, 55);
    tick();
    tick();
    check_now("pre_reset", 12'hF00);
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 12'h000);
    tick();
    rst_n = 1'b1;
    scan(95, 120, 45, 70);
    probe("after_reset", 105, 55, 12'h000);
    set_pos(100, 50, 1'b1, 1'b0, 1'b0);
    scan(95, 120, 45, 70);
    probe("en_no_frame", 105, 55, 12'h000);
    frame();
    probe("en_frame", 105, 55, 12'hF00);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
